ysyx_22040088_core_seq: RTL and testbench
=========================================

// Module: ysyx_22040088_core_seq
// PURPOSE
//  Multi-cycle sequencer for the NPC core. Steps IFU/IDU/EXU through FETCH, DECODE, EXEC/MEM and WB.
//  Runs ready-based handshakes to instruction and data memory.
//  Gates the register-file write and the PC update, and halts the core on ebreak or a bus timeout.
//  Instantiated in top, next to IFU/IDU/EXU. Also owns the cycle and instret performance counters.
// PARAMETERS
//  TMO_W    8    watchdog counter width
//  TMO_MAX  255  wait cycles allowed in FETCH/MEM before bus error; must be <= 2**TMO_W-1
// PORTS
//  clk           in   1   core clock
//  rst           in   1   synchronous reset, active-high
//  imem_req      out  1   fetch request; held high until imem_ready
//  imem_ready    in   1   fetch data valid this cycle
//  ir_we         out  1   latch inst into IR (one-cycle pulse)
//  dec_is_load   in   1   IDU decode: load; sampled in DECODE only
//  dec_is_store  in   1   IDU decode: store; sampled in DECODE only
//  dec_is_ebreak in   1   IDU decode: ebreak; sampled in DECODE only
//  dmem_req      out  1   data request; held high until dmem_ready
//  dmem_we       out  1   1 = store, 0 = load; valid while dmem_req
//  dmem_ready    in   1   data access complete this cycle
//  rf_we         out  1   register-file write enable (one-cycle pulse)
//  pc_we         out  1   PC update enable to IFU (one-cycle pulse)
//  halt          out  1   core halted; top calls finish_sim on its rising edge
//  bus_err       out  1   sticky: memory watchdog expired
//  cycle_cnt     out  64  cycles spent outside RST/HALT
//  instret       out  64  retired instructions
// BEHAVIOUR
//  States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT.
//  - rst=1 at any edge: state<=RST; counters, flags and watchdog <=0. Reset mid-handshake abandons it silently.
//  - In RST, and immediately after reset, every output is 0.
//  - RST -> FETCH unconditionally on the next edge.
//  - FETCH: imem_req=1.
//    - If imem_ready: ir_we=1 in that same cycle, then -> DECODE.
//  - DECODE (1 cycle): priority ebreak > load/store > other.
//    - ebreak: -> HALT, instret+1, no pc_we.
//    - load/store: latch is_store into a flop, -> MEM.
//    - other: -> EXEC.
//  - EXEC (1 cycle): -> WB.
//  - MEM: dmem_req=1, dmem_we=latched is_store.
//    - If dmem_ready: -> WB.
//  - WB (1 cycle): pc_we=1; rf_we=1 unless the instruction was a store; instret+1; -> FETCH.
//  - HALT: absorbing until rst. halt=1 (registered, rises on the HALT entry edge). All req/we outputs 0.
//  - Output timing:
//    - Moore (decoded from state): imem_req, dmem_req, dmem_we, rf_we, pc_we.
//    - Mealy: ir_we = (FETCH & imem_ready).
//    - Registered: halt, bus_err, cycle_cnt, instret.
//  - Watchdog:
//    - Cleared on entry to FETCH or MEM; counts +1 each cycle waiting there without ready.
//    - If the count equals TMO_MAX and ready=0: bus_err<=1, -> HALT.
//    - If ready arrives in the same cycle as the count reaches TMO_MAX, ready wins (no error).
//  - ready inputs are ignored outside their state. Decode inputs are ignored outside DECODE.
//  - Latency with zero-wait memory (ready in the first request cycle): ALU, load and store each take 4 cycles, FETCH to WB inclusive.
//  - Counters: 64-bit, wrap modulo 2^64, no saturation. cycle_cnt stops in HALT.
// STRUCTURE
//  - Shared header ysyx_22040088_defines.vh:
//    - state encoding localparams (3-bit);
//    - TMO defaults;
//    - EBREAK encoding 32'h0010_0073, so IDU and top use one constant.
//  - One sub-module: ysyx_22040088_wdog. Clear, enable, expire output; parameterised by TMO_W/TMO_MAX.
//  - FSM, output decode and counters stay in this module.
// TESTING
//  1. ALU stream, imem_ready tied 1, 3 instrs: pc_we pulses every 4 cycles; instret=3 and cycle_cnt=12 after 3 retires; rf_we pulses in WB.
//  2. Load, dmem_ready after 5 wait cycles: dmem_req high 6 cycles, dmem_we=0, then WB with rf_we=1. Store variant: dmem_we=1, rf_we=0 in WB.
//  3. ebreak decoded: next edge halt=1, pc_we never asserted, instret incremented; further imem_ready pulses have no effect.
//  4. Watchdog, TMO_MAX=4, imem_ready held 0: bus_err=1 and halt=1 after 5 FETCH cycles; ready on the 5th cycle -> DECODE instead, bus_err=0.
//  5. rst asserted while in MEM with dmem_req=1: the next cycle has all outputs 0 and counters 0; FETCH the cycle after; the old request never completes.
//  6. Spurious dmem_ready in FETCH/DECODE and dec_is_load asserted in EXEC: no state or output change.

Source files
------------

// File: rtl/ysyx_22040088_core_seq_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
// The IDU and top use the same EBREAK encoding from here.
package ysyx_22040088_core_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam int TMO_W_DEF   = 8;
  localparam int TMO_MAX_DEF = 255;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/ysyx_22040088_core_seq_wdog.sv
// Bus watchdog: counts wait cycles while enabled and flags expiry at TMO_MAX.
// The count freezes at TMO_MAX; the sequencer leaves the wait state on expiry.
module ysyx_22040088_wdog
  import ysyx_22040088_core_seq_pkg::*;
#(
  parameter int TMO_W   = TMO_W_DEF,
  parameter int TMO_MAX = TMO_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expired = (cnt == TMO_W'(TMO_MAX));

endmodule

// File: rtl/ysyx_22040088_core_seq.sv
// Multi-cycle sequencer for the NPC core: FETCH/DECODE/EXEC|MEM/WB with ready handshakes,
// write/PC gating, halt on ebreak or bus timeout, and cycle/instret counters.
module ysyx_22040088_core_seq
  import ysyx_22040088_core_seq_pkg::*;
#(
  parameter int TMO_W   = TMO_W_DEF,
  parameter int TMO_MAX = TMO_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_we,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_ebreak,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic        bus_err,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret
);

  state_e state;
  logic   is_store_q;
  logic   wd_clr;
  logic   wd_en;
  logic   wd_expired;

  // The only ways into FETCH/MEM pass through a state where the watchdog is held clear.
  assign wd_clr = (state != ST_FETCH) && (state != ST_MEM);
  assign wd_en  = ((state == ST_FETCH) && !imem_ready) ||
                  ((state == ST_MEM)   && !dmem_ready);

  ysyx_22040088_wdog #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RST;
      is_store_q <= 1'b0;
      halt       <= 1'b0;
      bus_err    <= 1'b0;
      cycle_cnt  <= '0;
      instret    <= '0;
    end else begin
      if ((state != ST_RST) && (state != ST_HALT)) begin
        cycle_cnt <= cycle_cnt + 64'd1;
      end
      case (state)
        ST_RST: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ready) begin
            state <= ST_DECODE;
          end else if (wd_expired) begin
            state   <= ST_HALT;
            halt    <= 1'b1;
            bus_err <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (dec_is_ebreak) begin
            state   <= ST_HALT;
            halt    <= 1'b1;
            instret <= instret + 64'd1;
          end else if (dec_is_load || dec_is_store) begin
            is_store_q <= dec_is_store;
            state      <= ST_MEM;
          end else begin
            is_store_q <= 1'b0;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: state <= ST_WB;
        ST_MEM: begin
          if (dmem_ready) begin
            state <= ST_WB;
          end else if (wd_expired) begin
            state   <= ST_HALT;
            halt    <= 1'b1;
            bus_err <= 1'b1;
          end
        end
        ST_WB: begin
          instret <= instret + 64'd1;
          state   <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RST;
      endcase
    end
  end

  // ir_we follows imem_ready combinationally so IR captures the word in its valid cycle.
  assign imem_req = (state == ST_FETCH);
  assign ir_we    = (state == ST_FETCH) && imem_ready;
  assign dmem_req = (state == ST_MEM);
  assign dmem_we  = (state == ST_MEM) && is_store_q;
  assign rf_we    = (state == ST_WB) && !is_store_q;
  assign pc_we    = (state == ST_WB);

endmodule

// File: tb/tb_ysyx_22040088_core_seq.sv
// Self-checking bench for ysyx_22040088_core_seq: instruction-level model with random wait
// states and noise on ignored inputs, compared every cycle against the outputs.
module tb_ysyx_22040088_core_seq;

  localparam int TMO_W   = 8;
  localparam int TMO_MAX = 5;

  localparam int K_ALU    = 0;
  localparam int K_LOAD   = 1;
  localparam int K_STORE  = 2;
  localparam int K_EBREAK = 3;

  localparam logic [7:0] IMREQ = 8'b1000_0000;
  localparam logic [7:0] IRWE  = 8'b0100_0000;
  localparam logic [7:0] DMREQ = 8'b0010_0000;
  localparam logic [7:0] DMWE  = 8'b0001_0000;
  localparam logic [7:0] RFWE  = 8'b0000_1000;
  localparam logic [7:0] PCWE  = 8'b0000_0100;
  localparam logic [7:0] HALT  = 8'b0000_0010;
  localparam logic [7:0] BERR  = 8'b0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready = 1'b0, ir_we;
  logic        dec_is_load = 1'b0, dec_is_store = 1'b0, dec_is_ebreak = 1'b0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic        rf_we, pc_we, halt, bus_err;
  logic [63:0] cycle_cnt, instret;
  logic [7:0]  outs;

  int              vectors     = 0;
  int              miscompares = 0;
  longint unsigned m_cycles    = 0;
  longint unsigned m_instret   = 0;
  bit              m_berr      = 1'b0;

  ysyx_22040088_core_seq #(.TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .ir_we         (ir_we),
    .dec_is_load   (dec_is_load),
    .dec_is_store  (dec_is_store),
    .dec_is_ebreak (dec_is_ebreak),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ready    (dmem_ready),
    .rf_we         (rf_we),
    .pc_we         (pc_we),
    .halt          (halt),
    .bus_err       (bus_err),
    .cycle_cnt     (cycle_cnt),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  assign outs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt, bus_err};

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic ir, input logic dr,
                       input logic ld, input logic st, input logic eb);
    @(negedge clk);
    rst           = r;
    imem_ready    = ir;
    dmem_ready    = dr;
    dec_is_load   = ld;
    dec_is_store  = st;
    dec_is_ebreak = eb;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    vectors++;
    if (outs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outs: got %b want %b", outs, 8'h00);
    end
    vectors++;
    if (cycle_cnt !== 64'd0 || instret !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got cycle=%0d instret=%0d want 0/0", cycle_cnt, instret);
    end
    m_cycles  = 0;
    m_instret = 0;
    m_berr    = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle; fw/mw are wait cycles before ready.
  // More than TMO_MAX waits means the bus never answers and the core halts with bus_err.
  task automatic run_instr(input int kind, input int fw, input int mw, output bit halted);
    logic [7:0] exp;
    bit         is_st;
    halted = 1'b0;
    is_st  = (kind == K_STORE);
    for (int i = 0; i <= fw; i++) begin
      drive(1'b0, 1'(i == fw), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      exp = IMREQ | ((i == fw) ? IRWE : 8'h00);
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL fetch_outs[%0d]: got %b want %b", i, outs, exp);
      end
      vectors++;
      if (cycle_cnt !== m_cycles || instret !== m_instret) begin
        miscompares++;
        $display("FAIL fetch_counters: got %0d/%0d want %0d/%0d", cycle_cnt, instret, m_cycles, m_instret);
      end
      m_cycles++;
      if (i == TMO_MAX && i != fw) begin
        m_berr = 1'b1;
        halted = 1'b1;
        return;
      end
    end
    drive(1'b0, 1'($urandom), 1'($urandom),
          (kind == K_LOAD) ? 1'b1 : ((kind == K_EBREAK) ? 1'($urandom) : 1'b0),
          (kind == K_STORE) ? 1'b1 : ((kind == K_EBREAK) ? 1'($urandom) : 1'b0),
          1'(kind == K_EBREAK));
    vectors++;
    if (outs !== 8'h00) begin
      miscompares++;
      $display("FAIL decode_outs: got %b want %b", outs, 8'h00);
    end
    m_cycles++;
    if (kind == K_EBREAK) begin
      m_instret++;
      halted = 1'b1;
      return;
    end
    if (kind == K_ALU) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 1'($urandom));
      vectors++;
      if (outs !== 8'h00) begin
        miscompares++;
        $display("FAIL exec_outs: got %b want %b", outs, 8'h00);
      end
      m_cycles++;
    end else begin
      for (int j = 0; j <= mw; j++) begin
        drive(1'b0, 1'($urandom), 1'(j == mw), 1'($urandom), 1'($urandom), 1'($urandom));
        exp = DMREQ | (is_st ? DMWE : 8'h00);
        vectors++;
        if (outs !== exp) begin
          miscompares++;
          $display("FAIL mem_outs[%0d]: got %b want %b", j, outs, exp);
        end
        m_cycles++;
        if (j == TMO_MAX && j != mw) begin
          m_berr = 1'b1;
          halted = 1'b1;
          return;
        end
      end
    end
    drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    exp = PCWE | (is_st ? 8'h00 : RFWE);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL wb_outs: got %b want %b", outs, exp);
    end
    vectors++;
    if (cycle_cnt !== m_cycles || instret !== m_instret) begin
      miscompares++;
      $display("FAIL wb_counters: got %0d/%0d want %0d/%0d", cycle_cnt, instret, m_cycles, m_instret);
    end
    m_cycles++;
    m_instret++;
  endtask

  // Halted core: ready pulses and decode noise must change nothing, counters frozen.
  task automatic test_halted(input int n);
    logic [7:0] exp;
    exp = HALT | (m_berr ? BERR : 8'h00);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL halted_outs[%0d]: got %b want %b", i, outs, exp);
      end
      vectors++;
      if (cycle_cnt !== m_cycles || instret !== m_instret) begin
        miscompares++;
        $display("FAIL halted_counters: got %0d/%0d want %0d/%0d", cycle_cnt, instret, m_cycles, m_instret);
      end
    end
  endtask

  task automatic test_alu_stream();
    bit h;
    test_reset();
    for (int k = 0; k < 3; k++) run_instr(K_ALU, 0, 0, h);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (instret !== 64'd3 || cycle_cnt !== 64'd12) begin
      miscompares++;
      $display("FAIL alu_stream_counters: got cycle=%0d instret=%0d want 12/3", cycle_cnt, instret);
    end
    m_cycles++;
  endtask

  task automatic test_mem();
    bit h;
    test_reset();
    run_instr(K_LOAD, 0, 5, h);
    run_instr(K_STORE, 0, 5, h);
    run_instr(K_ALU, 1, 0, h);
    run_instr(K_STORE, 2, TMO_MAX + 1, h);
    vectors++;
    if (!h) begin
      miscompares++;
      $display("FAIL mem_timeout_model: got halted=%0d want 1", h);
    end
    test_halted(3);
  endtask

  task automatic test_ebreak();
    bit h;
    test_reset();
    run_instr(K_ALU, 0, 0, h);
    run_instr(K_EBREAK, 1, 0, h);
    test_halted(6);
  endtask

  task automatic test_watchdog();
    bit h;
    test_reset();
    run_instr(K_ALU, TMO_MAX, 0, h);
    run_instr(K_LOAD, TMO_MAX, TMO_MAX, h);
    run_instr(K_ALU, TMO_MAX + 1, 0, h);
    test_halted(4);
  endtask

  task automatic test_reset_mid_mem();
    bit h;
    test_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (outs !== DMREQ) begin
      miscompares++;
      $display("FAIL pre_reset_mem: got %b want %b", outs, DMREQ);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (outs !== 8'h00 || cycle_cnt !== 64'd0 || instret !== 64'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got outs=%b cycle=%0d instret=%0d want 0/0/0", outs, cycle_cnt, instret);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (outs !== IMREQ) begin
      miscompares++;
      $display("FAIL post_reset_fetch: got %b want %b", outs, IMREQ);
    end
    m_cycles  = 1;
    m_instret = 0;
    m_berr    = 1'b0;
    run_instr(K_ALU, 0, 0, h);
  endtask

  task automatic test_random();
    bit h;
    test_reset();
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom_range(2), $urandom_range(TMO_MAX), $urandom_range(TMO_MAX), h);
    end
    run_instr(K_EBREAK, $urandom_range(TMO_MAX), 0, h);
    test_halted(3);
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_mem();
    test_ebreak();
    test_watchdog();
    test_reset_mid_mem();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no end of stimulus, want finish");
    $fatal(1, "simulation time limit");
  end

endmodule
